alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Program-memory driven sequencer that issues instructions to an
//               external ALU, with free-run, single-step and timeout handling.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer (
  input  logic        clk,
  input  logic        btnU,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [12:0] prog_data,
  input  logic        run,
  input  logic        step_mode,
  input  logic        btnC,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_data,
  output logic        alu_go,
  input  logic        alu_done,
  output logic [3:0]  pc,
  output logic        busy,
  output logic        halted,
  output logic        error
);

  localparam logic [3:0] C_WAIT_LIMIT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_STEP  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [12:0] r_mem [16];
  logic [12:0] r_ir;
  logic [3:0]  r_pc;
  logic [3:0]  r_alu_op;
  logic [7:0]  r_alu_data;
  logic [3:0]  r_wait_cnt;
  logic        r_error;

  logic        r_sync1;
  logic        r_sync2;
  logic        r_sync3;
  logic        r_step_pulse;

  logic        w_pc_clear;
  logic        w_pc_inc;
  logic        w_load_ir;
  logic        w_latch_alu;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic        w_err_set;
  logic        w_err_clear;
  logic        w_mem_we;
  logic [3:0]  w_cnt_plus1;

  assign w_cnt_plus1 = r_wait_cnt + 4'd1;
  assign w_mem_we    = prog_we && !btnU && (r_state == S_IDLE || r_state == S_HALT);

  // Program memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (btnU) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_step_pulse <= 1'b0;
    end else begin
      r_sync1      <= btnC;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_step_pulse <= r_sync2 & ~r_sync3;
    end
  end

  always_ff @(posedge clk) begin
    if (btnU) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_clear   = 1'b0;
    w_pc_inc     = 1'b0;
    w_load_ir    = 1'b0;
    w_latch_alu  = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err_set    = 1'b0;
    w_err_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_pc_clear   = 1'b1;
          w_err_clear  = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_load_ir    = 1'b1;
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_latch_alu  = 1'b1;
        w_cnt_clear  = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          if (r_ir[12]) begin
            w_state_next = S_HALT;
          end else if (step_mode) begin
            w_state_next = S_STEP;
          end else begin
            w_pc_inc     = 1'b1;
            w_state_next = S_FETCH;
          end
        end else if (w_cnt_plus1 == C_WAIT_LIMIT) begin
          // Fifteen silent WAIT cycles: give up on this instruction.
          w_err_set    = 1'b1;
          w_state_next = S_HALT;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_STEP: begin
        if (r_step_pulse || !step_mode) begin
          w_pc_inc     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_HALT: begin
        if (!run) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (btnU) begin
      r_pc       <= 4'd0;
      r_ir       <= 13'd0;
      r_alu_op   <= 4'd0;
      r_alu_data <= 8'd0;
      r_wait_cnt <= 4'd0;
      r_error    <= 1'b0;
    end else begin
      if (w_pc_clear) begin
        r_pc <= 4'd0;
      end else if (w_pc_inc) begin
        r_pc <= r_pc + 4'd1;
      end
      if (w_load_ir) begin
        r_ir <= r_mem[r_pc];
      end
      if (w_latch_alu) begin
        r_alu_op   <= r_ir[11:8];
        r_alu_data <= r_ir[7:0];
      end
      if (w_cnt_clear) begin
        r_wait_cnt <= 4'd0;
      end else if (w_cnt_inc) begin
        r_wait_cnt <= w_cnt_plus1;
      end
      if (w_err_clear) begin
        r_error <= 1'b0;
      end else if (w_err_set) begin
        r_error <= 1'b1;
      end
    end
  end

  // During ISSUE the ALU sees the instruction register directly; afterwards the latched copy.
  assign alu_op   = (r_state == S_ISSUE) ? r_ir[11:8] : r_alu_op;
  assign alu_data = (r_state == S_ISSUE) ? r_ir[7:0]  : r_alu_data;
  assign alu_go   = (r_state == S_ISSUE);
  assign pc       = r_pc;
  assign busy     = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign halted   = (r_state == S_HALT);
  assign error    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Scoreboard bench for alu_sequencer with an ALU responder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk       = 1'b0;
  logic        btnU      = 1'b0;
  logic        prog_we   = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [12:0] prog_data = 13'd0;
  logic        run       = 1'b0;
  logic        step_mode = 1'b0;
  logic        btnC      = 1'b0;
  logic        alu_done  = 1'b0;
  logic [3:0]  alu_op;
  logic [7:0]  alu_data;
  logic        alu_go;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        error;

  alu_sequencer dut (
    .clk       (clk),
    .btnU      (btnU),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .run       (run),
    .step_mode (step_mode),
    .btnC      (btnC),
    .alu_op    (alu_op),
    .alu_data  (alu_data),
    .alu_go    (alu_go),
    .alu_done  (alu_done),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
    logic [3:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [12:0] model_mem [16];
  int          tests      = 0;
  int          fails      = 0;
  int          go_seen    = 0;
  int          resp_go    = 0;
  int          resp_cnt   = 0;
  int          done_limit = 0;
  int          max_delay  = 1;
  logic        prev_go    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every alu_go pulse is matched against the next expected issue.
  always @(negedge clk) begin
    if (alu_go === 1'b1) begin
      go_seen++;
      check("go_not_back_to_back", {31'd0, prev_go}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_go: got op=%0h data=%0h pc=%0d, required no issue", alu_op, alu_data, pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("go_op",   {28'd0, alu_op},   {28'd0, mon_e.op});
        check("go_data", {24'd0, alu_data}, {24'd0, mon_e.data});
        check("go_pc",   {28'd0, pc},       {28'd0, mon_e.pc});
      end
    end
    prev_go = alu_go;
  end

  // ALU responder: acknowledges the first done_limit issues after a random delay.
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (btnU) begin
      resp_cnt = 0;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) alu_done = 1'b1;
    end
    if (alu_go === 1'b1) begin
      if (resp_go < done_limit && !btnU) resp_cnt = int'($urandom_range(max_delay, 1));
      resp_go++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btnU = 1'b1;
    run  = 1'b0;
    tick(2);
    btnU = 1'b0;
  endtask

  task automatic load_model();
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = i[3:0];
      prog_data = model_mem[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  // Reference: walk the program from address 0 following the last-bit rule.
  task automatic push_expect(input int max_n);
    int p;
    p = 0;
    for (int i = 0; i < max_n; i++) begin
      exp_t e;
      e.op   = model_mem[p][11:8];
      e.data = model_mem[p][7:0];
      e.pc   = p[3:0];
      exp_q.push_back(e);
      if (model_mem[p][12]) break;
      p = (p + 1) % 16;
    end
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  task automatic end_run(input string name);
    run = 1'b0;
    tick(2);
    check({name, "_idle_halted"}, {31'd0, halted}, 32'd0);
    check({name, "_idle_busy"},   {31'd0, busy},   32'd0);
  endtask

  task automatic basic_program();
    for (int i = 0; i < 16; i++) model_mem[i] = 13'($urandom);
    model_mem[0] = 13'h0F05;
    model_mem[1] = 13'h0F03;
    model_mem[2] = 13'h1000;
  endtask

  initial begin
    int base;
    int n;
    int len;

    // Reset state
    do_reset();
    check("rst_pc",     {28'd0, pc},       32'd0);
    check("rst_op",     {28'd0, alu_op},   32'd0);
    check("rst_data",   {24'd0, alu_data}, 32'd0);
    check("rst_go",     {31'd0, alu_go},   32'd0);
    check("rst_busy",   {31'd0, busy},     32'd0);
    check("rst_halted", {31'd0, halted},   32'd0);
    check("rst_error",  {31'd0, error},    32'd0);

    // Three-instruction program, free-run, done one cycle after each go
    basic_program();
    load_model();
    done_limit = resp_go + 1000;
    max_delay  = 1;
    push_expect(16);
    base = go_seen;
    run  = 1'b1;
    wait_halted("basic", 60);
    tick(1);
    check("basic_pc",     {28'd0, pc},    32'd2);
    check("basic_error",  {31'd0, error}, 32'd0);
    check("basic_goes",   go_seen - base, 32'd3);
    check("basic_queue",  exp_q.size(),   32'd0);
    tick(3);
    check("basic_hold_halt", {31'd0, halted}, 32'd1);
    end_run("basic");

    // Timeout: no done after the first issue
    done_limit = resp_go;
    push_expect(1);
    base = go_seen;
    run  = 1'b1;
    n    = 0;
    while (alu_go !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_go_seen", {31'd0, alu_go}, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("timeout_not_yet_halted", {31'd0, halted}, 32'd0);
      if (k == 16) begin
        check("timeout_halted", {31'd0, halted}, 32'd1);
        check("timeout_error",  {31'd0, error},  32'd1);
      end
    end
    tick(10);
    check("timeout_single_go", go_seen - base, 32'd1);
    end_run("timeout");
    check("timeout_error_sticky", {31'd0, error}, 32'd1);
    exp_q.delete();

    // Single-step: one issue per button press
    done_limit = resp_go + 1000;
    step_mode  = 1'b1;
    push_expect(16);
    base = go_seen;
    run  = 1'b1;
    tick(3);
    check("step_error_cleared", {31'd0, error}, 32'd0);
    tick(17);
    check("step_first_go", go_seen - base, 32'd1);
    for (int press = 1; press <= 3; press++) begin
      btnC = 1'b1;
      tick(4);
      btnC = 1'b0;
      tick(20);
      check("step_go_per_press", go_seen - base, (press < 3) ? 32'(press + 1) : 32'd3);
    end
    check("step_halted", {31'd0, halted}, 32'd1);
    check("step_pc",     {28'd0, pc},     32'd2);
    step_mode = 1'b0;
    end_run("step");

    // Reset during WAIT of the second instruction
    done_limit = resp_go + 1;
    push_expect(16);
    base = go_seen;
    run  = 1'b1;
    n    = 0;
    len  = 0;
    while (len < 2 && n < 40) begin
      @(negedge clk);
      n++;
      if (alu_go === 1'b1) len++;
    end
    check("mid_reset_two_goes", len, 32'd2);
    @(negedge clk);
    btnU = 1'b1;
    run  = 1'b0;
    @(negedge clk);
    btnU = 1'b0;
    check("mid_reset_pc",     {28'd0, pc},       32'd0);
    check("mid_reset_op",     {28'd0, alu_op},   32'd0);
    check("mid_reset_data",   {24'd0, alu_data}, 32'd0);
    check("mid_reset_go",     {31'd0, alu_go},   32'd0);
    check("mid_reset_busy",   {31'd0, busy},     32'd0);
    check("mid_reset_halted", {31'd0, halted},   32'd0);
    check("mid_reset_error",  {31'd0, error},    32'd0);
    exp_q.delete();
    tick(10);
    check("mid_reset_no_more_go", go_seen - base, 32'd2);
    done_limit = resp_go + 1000;
    push_expect(16);
    base = go_seen;
    run  = 1'b1;
    wait_halted("rerun", 60);
    tick(1);
    check("rerun_pc",   {28'd0, pc},    32'd2);
    check("rerun_goes", go_seen - base, 32'd3);
    end_run("rerun");

    // Random programs with random ALU latency
    for (int it = 0; it < 4; it++) begin
      len = int'($urandom_range(16, 1));
      for (int i = 0; i < 16; i++) begin
        model_mem[i] = 13'($urandom);
        if (i < len) model_mem[i][12] = (i == len - 1);
      end
      load_model();
      max_delay  = 4;
      done_limit = resp_go + 1000;
      push_expect(16);
      base = go_seen;
      run  = 1'b1;
      wait_halted("rand", 200);
      tick(1);
      check("rand_pc",    {28'd0, pc},    32'(len - 1));
      check("rand_error", {31'd0, error}, 32'd0);
      check("rand_goes",  go_seen - base, 32'(len));
      end_run("rand");
    end

    // Wrap: sixteen instructions, none marked last
    for (int i = 0; i < 16; i++) model_mem[i] = {1'b0, 12'($urandom)};
    load_model();
    max_delay  = 2;
    done_limit = resp_go + 1000;
    push_expect(17);
    base = go_seen;
    run  = 1'b1;
    n    = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wrap_queue_drained", exp_q.size(), 32'd0);
    btnU = 1'b1;
    run  = 1'b0;
    @(negedge clk);
    btnU = 1'b0;
    tick(5);
    check("wrap_goes", go_seen - base, 32'd17);

    // Program writes while busy must be ignored
    basic_program();
    load_model();
    max_delay  = 4;
    done_limit = resp_go + 1000;
    push_expect(16);
    run = 1'b1;
    n   = 0;
    while (halted !== 1'b1 && n < 80) begin
      if (busy === 1'b1) begin
        prog_we   = 1'b1;
        prog_addr = 4'($urandom_range(2, 0));
        prog_data = 13'($urandom);
      end else begin
        prog_we = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    prog_we = 1'b0;
    check("we_busy_halted", {31'd0, halted}, 32'd1);
    check("we_busy_pc",     {28'd0, pc},     32'd2);
    end_run("we_busy");
    push_expect(16);
    base = go_seen;
    run  = 1'b1;
    wait_halted("we_readback", 80);
    tick(1);
    check("we_readback_goes", go_seen - base, 32'd3);
    check("we_readback_pc",   {28'd0, pc},    32'd2);
    end_run("we_readback");

    tick(5);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
